// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   WORD_BYTES    : byte stride between consecutive instruction words
//   fetch_entry_t : {pc, instr} pair carried through the prefetch queue
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fetch_entry_t.
// The head entry is kept in a register so that it holds its last value when the queue
// empties.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear; dominates wr_en and rd_en
//   wr_en        : push wr_data at the tail (ignored when full and not popping)
//   wr_data      : entry to push
//   rd_en        : pop the head (ignored when empty)
//   rd_data      : head entry (registered)
//   valid        : queue is non-empty (registered)
//   full         : queue holds DEPTH entries (registered)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    output fetch_entry_t rd_data,
    output logic         valid,
    output logic         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    fetch_entry_t       head_q, head_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;
    logic               wr_ok, rd_ok;

    // Next-state for storage, pointers, count and the registered head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        // A full queue may still accept a write when the head leaves in the same cycle.
        wr_ok    = wr_en & (~full_q | (rd_en & valid_q));
        rd_ok    = rd_en & valid_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end

        // Head is taken from the post-update array, so a write into an empty queue
        // shows up at the head after the same edge (no same-cycle bypass).
        if (cnt_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end

        valid_d = (cnt_d != '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign rd_data = head_q;
    assign valid   = valid_q;
    assign full    = full_q;

endmodule : fetch_queue

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads imem combinationally, buffers {pc, instr}
// pairs in a prefetch queue and hands them to decode over valid/ready.
// A redirect flushes the queue and reloads the PC.
//   clk, reset_n          : clock, asynchronous active-low reset
//   fetch_en              : allow fetch (PC advance and push)
//   imem_a / imem_rd      : imem byte address (= PC) and same-cycle read data
//   redirect, redirect_pc : PC override pulse and target (low two bits dropped)
//   out_valid/out_ready   : handshake to decode
//   out_instr, out_pc     : head entry
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pop, push;
    logic            q_valid, q_full;
    fetch_entry_t    wr_entry, head;
    logic [1:0]      unused_redirect_lsbs;

    // Handshake, push gating and next PC; redirect outranks push.
    always_comb begin
        pop      = q_valid & out_ready;
        push     = fetch_en & ~redirect & (~q_full | pop);
        wr_entry = '{pc: pc_q, instr: imem_rd};
        pc_d     = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + XLEN'(WORD_BYTES);
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A pop in the redirect cycle is still delivered; the flush clears what remains.
    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .valid   (q_valid),
        .full    (q_full)
    );

    assign imem_a               = pc_q;
    assign out_valid            = q_valid;
    assign out_instr            = head.instr;
    assign out_pc               = head.pc;
    assign unused_redirect_lsbs = redirect_pc[1:0];

    // RESET_PC must be word aligned.
    always_ff @(posedge clk) begin
        assert (RESET_PC[1:0] == 2'b00)
            else $error("instr_fetch_unit: RESET_PC %h is not word aligned", RESET_PC);
    end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. imem model: word i holds i+1.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int total;
    int bad;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_en    (fetch_en),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    assign imem_rd = (imem_a >> 2) + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, ins);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        fetch_en    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        step();
        step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.pc", out_pc, 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.imem_a", imem_a, 32'd0);

        // Streaming with out_ready held: pc 0,4,8 on consecutive cycles
        reset_n   = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        chk_head("s0", 32'h0, 32'd1);
        chk("s0.imem_a", imem_a, 32'h4);
        step();
        chk_head("s1", 32'h4, 32'd2);
        step();
        chk_head("s2", 32'h8, 32'd3);
        chk("s2.imem_a", imem_a, 32'hC);

        // Stall 5 cycles: queue fills with 8,12, PC stalls at 16
        out_ready = 1'b0;
        repeat (5) step();
        chk_head("stall", 32'h8, 32'd3);
        chk("stall.imem_a", imem_a, 32'h10);

        // Full + pop: push and pop together, PC advances by 4
        out_ready = 1'b1;
        step();
        chk_head("fullpop", 32'hC, 32'd4);
        chk("fullpop.imem_a", imem_a, 32'h14);
        step();
        chk_head("drain", 32'h10, 32'd5);
        chk("drain.imem_a", imem_a, 32'h18);

        // Redirect to 0x43 with queue holding {16,20}
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        out_ready   = 1'b0;
        step();
        redirect  = 1'b0;
        out_ready = 1'b1;
        chk("redir.valid", 32'(out_valid), 32'd0);
        chk("redir.imem_a", imem_a, 32'h40);
        step();
        chk_head("redir_tgt", 32'h40, 32'd17);

        // Back-to-back redirects: last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_pc = 32'h0000_0205;
        step();
        redirect = 1'b0;
        chk("b2b.valid", 32'(out_valid), 32'd0);
        chk("b2b.imem_a", imem_a, 32'h204);
        step();
        chk_head("b2b_tgt", 32'h204, 32'h82);

        // fetch_en low for 3 cycles: queue drains, PC frozen at 0x208
        fetch_en = 1'b0;
        step();
        chk("fe0.valid", 32'(out_valid), 32'd0);
        chk("fe0.imem_a", imem_a, 32'h208);
        step();
        step();
        chk("fe2.valid", 32'(out_valid), 32'd0);
        chk("fe2.imem_a", imem_a, 32'h208);
        fetch_en = 1'b1;
        step();
        chk_head("fe_resume", 32'h208, 32'h83);

        // Async reset between edges clears state immediately
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.imem_a", imem_a, 32'h0);
        chk("arst.pc", out_pc, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        chk_head("restart0", 32'h0, 32'd1);
        step();
        chk_head("restart1", 32'h4, 32'd2);

        // PC wrap: misaligned redirect to the last word, then wrap to 0
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        chk("wrap.valid", 32'(out_valid), 32'd0);
        chk("wrap.imem_a", imem_a, 32'hFFFF_FFFC);
        step();
        chk_head("wrap_tgt", 32'hFFFF_FFFC, 32'h4000_0000);
        chk("wrap.imem_a0", imem_a, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch_unit
